// File: rtl/pss_mask_rsp_if.sv
// PSS mask-read request/data handshake plus the config write port.
// PSS_MASK_WR_BEN_EN adds a per-byte write enable to the config port.
interface pss_mask_rsp_if #(
  parameter int SRAM_WIDTH      = 256,
  parameter int MASK_ADDR_WIDTH = 5
);
  logic [MASK_ADDR_WIDTH-1:0] PSSGLB_MaskRdAddr;
  logic                       PSSGLB_MaskRdAddrVld;
  logic                       GLBPSS_MaskRdAddrRdy;
  logic [SRAM_WIDTH-1:0]      GLBPSS_MaskDatOut;
  logic                       GLBPSS_MaskDatOutVld;
  logic                       PSSGLB_MaskDatRdy;
  logic [MASK_ADDR_WIDTH-1:0] CFGMSK_WrAddr;
  logic [SRAM_WIDTH-1:0]      CFGMSK_WrDat;
  logic                       CFGMSK_WrVld;
  logic                       CFGMSK_WrRdy;
  logic                       CFGMSK_Clr;
`ifdef PSS_MASK_WR_BEN_EN
  logic [SRAM_WIDTH/8-1:0]    CFGMSK_WrBen;
`endif

  modport master (
`ifdef PSS_MASK_WR_BEN_EN
    output CFGMSK_WrBen,
`endif
    output PSSGLB_MaskRdAddr,
    output PSSGLB_MaskRdAddrVld,
    input  GLBPSS_MaskRdAddrRdy,
    input  GLBPSS_MaskDatOut,
    input  GLBPSS_MaskDatOutVld,
    output PSSGLB_MaskDatRdy,
    output CFGMSK_WrAddr,
    output CFGMSK_WrDat,
    output CFGMSK_WrVld,
    input  CFGMSK_WrRdy,
    output CFGMSK_Clr
  );

  modport slave (
`ifdef PSS_MASK_WR_BEN_EN
    input  CFGMSK_WrBen,
`endif
    input  PSSGLB_MaskRdAddr,
    input  PSSGLB_MaskRdAddrVld,
    output GLBPSS_MaskRdAddrRdy,
    output GLBPSS_MaskDatOut,
    output GLBPSS_MaskDatOutVld,
    input  PSSGLB_MaskDatRdy,
    input  CFGMSK_WrAddr,
    input  CFGMSK_WrDat,
    input  CFGMSK_WrVld,
    output CFGMSK_WrRdy,
    input  CFGMSK_Clr
  );
endinterface

// File: rtl/pss_mask_rsp.sv
// Mask array responder: 1-cycle SRAM read, bypass-or-FIFO response path.
// PSS_MASK_WR_BEN_EN enables byte-masked config writes.
module pss_mask_rsp #(
  parameter int SRAM_WIDTH      = 256,
  parameter int MASK_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH      = 2
) (
  input logic          clk,
  input logic          rst_n,
  pss_mask_rsp_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = 2 ** MASK_ADDR_WIDTH;

  logic [SRAM_WIDTH-1:0] mem [NW];
  logic [SRAM_WIDTH-1:0] fifo [FIFO_DEPTH];
  logic [SRAM_WIDTH-1:0] q;
  logic [CW-1:0]         cnt;
  logic [CW:0]           occ;
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic                  inflight;
  logic                  rdAcc;
  logic                  wrAcc;
  logic                  empty;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count both buffered words and the word still in the SRAM.
  assign occ = {1'b0, cnt} + {{CW{1'b0}}, inflight};
  assign bus.GLBPSS_MaskRdAddrRdy =
    ~bus.CFGMSK_Clr & (occ < (CW+1)'(FIFO_DEPTH));

  assign rdAcc = bus.PSSGLB_MaskRdAddrVld & bus.GLBPSS_MaskRdAddrRdy;
  assign bus.CFGMSK_WrRdy = ~rdAcc;
  assign wrAcc = bus.CFGMSK_WrVld & ~rdAcc;

  assign empty = (cnt == '0);
  assign bus.GLBPSS_MaskDatOutVld = ~empty | inflight;
  assign bus.GLBPSS_MaskDatOut =
    !empty   ? fifo[rp] :
    inflight ? q        : '0;

  assign pop  = ~empty & bus.PSSGLB_MaskDatRdy;
  assign push = inflight & ~(empty & bus.PSSGLB_MaskDatRdy);

  always_ff @(posedge clk) begin
    if (rdAcc) begin
      q <= mem[bus.PSSGLB_MaskRdAddr];
    end else if (wrAcc) begin
`ifdef PSS_MASK_WR_BEN_EN
      for (int b = 0; b < SRAM_WIDTH / 8; b++) begin
        if (bus.CFGMSK_WrBen[b])
          mem[bus.CFGMSK_WrAddr][b*8 +: 8] <= bus.CFGMSK_WrDat[b*8 +: 8];
      end
`else
      mem[bus.CFGMSK_WrAddr] <= bus.CFGMSK_WrDat;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push & ~bus.CFGMSK_Clr)
      fifo[wp] <= q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      wp       <= '0;
      rp       <= '0;
      inflight <= 1'b0;
    end else if (bus.CFGMSK_Clr) begin
      cnt      <= '0;
      wp       <= '0;
      rp       <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rdAcc;
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_pss_mask_rsp.sv
// Directed per-cycle vector bench for pss_mask_rsp.
// Define PSS_MASK_WR_BEN_EN to also exercise byte-enabled writes.
module tb_pss_mask_rsp;
  localparam int SW = 256;
  localparam int AW = 5;

  typedef struct {
    logic          rdVld;
    logic [AW-1:0] rdAddr;
    logic          wrVld;
    logic [AW-1:0] wrAddr;
    logic [SW-1:0] wrDat;
    logic [31:0]   wrBen;
    logic          datRdy;
    logic          clr;
    logic          eARdy;
    logic          eWRdy;
    logic          eVld;
    logic [SW-1:0] eDat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nTests = 0;
  int   nFail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pss_mask_rsp_if #(.SRAM_WIDTH(SW), .MASK_ADDR_WIDTH(AW)) bus ();

  pss_mask_rsp #(
    .SRAM_WIDTH(SW), .MASK_ADDR_WIDTH(AW), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic logic [SW-1:0] pat(input int a);
    logic [31:0] w;
    if (a == 3) return {32{8'hA5}};
    w = 32'h5A5A_0000 | a;
    return {8{w}};
  endfunction

  function automatic void add(
    input int rv, input int ra, input int wv, input int wa,
    input logic [SW-1:0] wd, input int dr, input int cl,
    input int ear, input int ewr, input int ev,
    input logic [SW-1:0] ed
  );
    vec_t v;
    v.rdVld  = rv[0];
    v.rdAddr = AW'(ra);
    v.wrVld  = wv[0];
    v.wrAddr = AW'(wa);
    v.wrDat  = wd;
    v.wrBen  = '1;
    v.datRdy = dr[0];
    v.clr    = cl[0];
    v.eARdy  = ear[0];
    v.eWRdy  = ewr[0];
    v.eVld   = ev[0];
    v.eDat   = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk1(input string nm, input int row,
                      input logic got, input logic exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s row %0d: got %b want %b", nm, row, got, exp);
    end
  endtask

  task automatic chkW(input string nm, input int row,
                      input logic [SW-1:0] got, input logic [SW-1:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.PSSGLB_MaskRdAddrVld = v.rdVld;
    bus.PSSGLB_MaskRdAddr    = v.rdAddr;
    bus.CFGMSK_WrVld         = v.wrVld;
    bus.CFGMSK_WrAddr        = v.wrAddr;
    bus.CFGMSK_WrDat         = v.wrDat;
    bus.PSSGLB_MaskDatRdy    = v.datRdy;
    bus.CFGMSK_Clr           = v.clr;
`ifdef PSS_MASK_WR_BEN_EN
    bus.CFGMSK_WrBen         = v.wrBen;
`endif
  endtask

  initial begin
    logic [SW-1:0] z;
    logic [SW-1:0] x9;
    logic [SW-1:0] y10;
    z   = '0;
    x9  = {8{32'hDEAD_BEEF}};
    y10 = {8{32'h1234_5678}};

    for (int a = 0; a < 8; a++)
      add(0, 0, 1, a, pat(a), 1, 0, 1, 1, 0, z);
    // single read of addr 3
    add(1, 3, 0, 0, z, 1, 0, 1, 0, 0, z);
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 1, pat(3));
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 0, z);
    // back-to-back 0..7
    for (int i = 0; i < 8; i++)
      add(1, i, 0, 0, z, 1, 0, 1, 0, (i > 0) ? 1 : 0,
          (i > 0) ? pat(i - 1) : z);
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 1, pat(7));
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 0, z);
    // backpressure fills the FIFO
    add(1, 1, 0, 0, z, 0, 0, 1, 0, 0, z);
    add(1, 2, 0, 0, z, 0, 0, 1, 0, 1, pat(1));
    add(1, 3, 0, 0, z, 0, 0, 0, 1, 1, pat(1));
    add(1, 3, 0, 0, z, 0, 0, 0, 1, 1, pat(1));
    add(1, 3, 0, 0, z, 1, 0, 0, 1, 1, pat(1));
    add(1, 3, 0, 0, z, 1, 0, 1, 0, 1, pat(2));
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 1, pat(3));
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 0, z);
    // read/write collision, then read-after-write
    add(1, 4, 1, 9, x9, 1, 0, 1, 0, 0, z);
    add(0, 0, 1, 9, x9, 1, 0, 1, 1, 1, pat(4));
    add(1, 9, 0, 0, z, 1, 0, 1, 0, 0, z);
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 1, x9);
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 0, z);
    // simultaneous push and pop with pointer wrap
    add(1, 0, 0, 0, z, 0, 0, 1, 0, 0, z);
    add(1, 1, 0, 0, z, 0, 0, 1, 0, 1, pat(0));
    add(0, 0, 0, 0, z, 1, 0, 0, 1, 1, pat(0));
    add(1, 2, 0, 0, z, 1, 0, 1, 0, 1, pat(1));
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 1, pat(2));
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 0, z);
    // flush with two buffered words
    add(1, 6, 0, 0, z, 0, 0, 1, 0, 0, z);
    add(1, 7, 0, 0, z, 0, 0, 1, 0, 1, pat(6));
    add(0, 0, 0, 0, z, 0, 0, 0, 1, 1, pat(6));
    add(1, 0, 0, 0, z, 0, 1, 0, 1, 1, pat(6));
    add(0, 0, 0, 0, z, 0, 0, 1, 1, 0, z);
    add(1, 5, 0, 0, z, 1, 0, 1, 0, 0, z);
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 1, pat(5));
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 0, z);
    // flush drops an in-flight read
    add(1, 1, 0, 0, z, 0, 0, 1, 0, 0, z);
    add(0, 0, 0, 0, z, 0, 1, 0, 1, 1, pat(1));
    add(0, 0, 0, 0, z, 0, 0, 1, 1, 0, z);
    // write during flush is kept
    add(0, 0, 1, 10, y10, 0, 1, 0, 1, 0, z);
    add(1, 10, 0, 0, z, 1, 0, 1, 0, 0, z);
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 1, y10);
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 0, z);
`ifdef PSS_MASK_WR_BEN_EN
    add(0, 0, 1, 2, '1, 1, 0, 1, 1, 0, z);
    add(0, 0, 1, 2, z, 1, 0, 1, 1, 0, z);
    vecs[$].wrBen = 32'h0000_0001;
    add(0, 0, 1, 2, z, 1, 0, 1, 1, 0, z);
    vecs[$].wrBen = 32'h0000_0000;
    add(1, 2, 0, 0, z, 1, 0, 1, 0, 0, z);
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 1, {{31{8'hFF}}, 8'h00});
    add(0, 0, 0, 0, z, 1, 0, 1, 1, 0, z);
`endif

    drive(vecs[0]);
    bus.PSSGLB_MaskRdAddrVld = 1'b0;
    bus.CFGMSK_WrVld = 1'b0;
    bus.CFGMSK_Clr = 1'b0;
    #12;
    chk1("rst_vld", -1, bus.GLBPSS_MaskDatOutVld, 1'b0);
    chkW("rst_dat", -1, bus.GLBPSS_MaskDatOut, z);
    chk1("rst_ardy", -1, bus.GLBPSS_MaskRdAddrRdy, 1'b1);
    chk1("rst_wrdy", -1, bus.CFGMSK_WrRdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    chk1("post_rst_vld", -1, bus.GLBPSS_MaskDatOutVld, 1'b0);

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      drive(vecs[r]);
      @(negedge clk);
      chk1("addr_rdy", r, bus.GLBPSS_MaskRdAddrRdy, vecs[r].eARdy);
      chk1("wr_rdy", r, bus.CFGMSK_WrRdy, vecs[r].eWRdy);
      chk1("dat_vld", r, bus.GLBPSS_MaskDatOutVld, vecs[r].eVld);
      if (vecs[r].eVld)
        chkW("dat", r, bus.GLBPSS_MaskDatOut, vecs[r].eDat);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
